// File: rtl/wb_gpio_irq_if.sv
// Purpose: Wishbone-classic slave bus bundle for the user-project GPIO block.
// Latency: none (wires only).
// Backpressure: the slave stalls a master simply by holding wbs_ack_o low.
// Ports: wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i are driven by the master;
//        wbs_dat_o/ack_o are driven by the slave.
interface wb_gpio_irq_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/wb_gpio_irq.sv
// Purpose: GPIO out/oe/in registers plus edge-detect sticky W1C interrupt status.
// Latency: ack and read data one cycle after request; io_in edge -> irq after 3 edges.
// Backpressure: none; every in-window request is acked exactly once, one cycle later.
// Ports: wb_clk_i, wb_rst_n (async active low), wbs (Wishbone slave modport),
//        io_in (async pads), io_out / io_oeb (pad drive, oeb active low), irq (level).
module wb_gpio_irq #(
  parameter int          NIO       = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_n,
  wb_gpio_irq_if.slave   wbs,
  input  logic [NIO-1:0] io_in,
  output logic [NIO-1:0] io_out,
  output logic [NIO-1:0] io_oeb,
  output logic           irq
);

  localparam logic [7:0] OFF_OUT   = 8'h00;
  localparam logic [7:0] OFF_OE    = 8'h04;
  localparam logic [7:0] OFF_IN    = 8'h08;
  localparam logic [7:0] OFF_IEN   = 8'h0C;
  localparam logic [7:0] OFF_STAT  = 8'h10;
  localparam logic [7:0] OFF_RISE  = 8'h14;
  localparam logic [7:0] OFF_FALL  = 8'h18;

  // Bits at or above NIO are never written, so they stay 0 and read back 0.
  localparam logic [31:0] VMASK = (NIO >= 32) ? 32'hFFFF_FFFF
                                              : ((32'd1 << NIO) - 32'd1);

  logic [31:0] out_r, oe_r, ien_r, stat_r, rise_en_r, fall_en_r;
  logic [31:0] s1_r, s2_r, prev_r;
  logic        ack_r;
  logic [31:0] dat_r;

  logic        hit, req, wr;
  logic [7:0]  off;
  logic [31:0] lane_mask, wmask, wdat, rdata, in_ext;
  logic [31:0] set_v, clr_v;

  // Only the upper 24 address bits select the block; the low byte is the offset.
  assign hit = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // ~ack_r turns a held strobe into one transfer every two cycles.
  assign req = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit & ~ack_r;
  assign wr  = req & wbs.wbs_we_i;
  assign off = wbs.wbs_adr_i[7:0];

  assign lane_mask = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                      {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};
  assign wmask = lane_mask & VMASK;
  assign wdat  = wbs.wbs_dat_i;

  always_comb begin
    in_ext = '0;
    in_ext[NIO-1:0] = io_in;
  end

  // Edge detect on the synchronized value against the previous synchronized value.
  assign set_v = ((s2_r & ~prev_r & rise_en_r) | (~s2_r & prev_r & fall_en_r)) & VMASK;
  assign clr_v = (wr && off == OFF_STAT) ? (wdat & wmask) : 32'h0;

  always_comb begin
    rdata = 32'h0;
    case (off)
      OFF_OUT:  rdata = out_r;
      OFF_OE:   rdata = oe_r;
      OFF_IN:   rdata = s2_r;
      OFF_IEN:  rdata = ien_r;
      OFF_STAT: rdata = stat_r;
      OFF_RISE: rdata = rise_en_r;
      OFF_FALL: rdata = fall_en_r;
      default:  rdata = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      out_r     <= '0;
      oe_r      <= '0;
      ien_r     <= '0;
      stat_r    <= '0;
      rise_en_r <= '0;
      fall_en_r <= '0;
      s1_r      <= '0;
      s2_r      <= '0;
      prev_r    <= '0;
      ack_r     <= 1'b0;
      dat_r     <= '0;
    end else begin
      ack_r <= req;
      // Read data exists only in the ack cycle; zero otherwise.
      dat_r <= (req && !wbs.wbs_we_i) ? rdata : 32'h0;

      s1_r   <= in_ext & VMASK;
      s2_r   <= s1_r;
      prev_r <= s2_r;

      if (wr) begin
        case (off)
          OFF_OUT:  out_r     <= (out_r     & ~wmask) | (wdat & wmask);
          OFF_OE:   oe_r      <= (oe_r      & ~wmask) | (wdat & wmask);
          OFF_IEN:  ien_r     <= (ien_r     & ~wmask) | (wdat & wmask);
          OFF_RISE: rise_en_r <= (rise_en_r & ~wmask) | (wdat & wmask);
          OFF_FALL: fall_en_r <= (fall_en_r & ~wmask) | (wdat & wmask);
          default:  ;
        endcase
      end

      // A new edge on the same cycle as a W1C keeps the bit set.
      stat_r <= (stat_r & ~clr_v) | set_v;
    end
  end

  assign wbs.wbs_ack_o = ack_r;
  assign wbs.wbs_dat_o = dat_r;
  assign io_out        = out_r[NIO-1:0];
  assign io_oeb        = ~oe_r[NIO-1:0];
  assign irq           = |(stat_r & ien_r);

endmodule
